// File: rtl/writeback_unit_if.sv
// rtl/writeback_unit_if.sv - producer, register-file write and decode-check signals of the writeback unit
interface writeback_unit_if #(
  parameter int REG_BITS  = 32,
  parameter int ADDR_BITS = 5
);
  logic                 alu_valid;
  logic [ADDR_BITS-1:0] alu_rd;
  logic [REG_BITS-1:0]  alu_result;
  logic                 ld_issue;
  logic [ADDR_BITS-1:0] ld_issue_rd;
  logic                 ld_valid;
  logic                 ld_ready;
  logic [ADDR_BITS-1:0] ld_rd;
  logic [REG_BITS-1:0]  ld_data;
  logic [2:0]           ld_funct3;
  logic [1:0]           ld_offset;
  logic                 we3;
  logic [ADDR_BITS-1:0] a3;
  logic [REG_BITS-1:0]  wd3;
  logic [ADDR_BITS-1:0] chk_a1;
  logic [ADDR_BITS-1:0] chk_a2;
  logic                 busy1;
  logic                 busy2;

  modport master (
    output alu_valid, alu_rd, alu_result, ld_issue, ld_issue_rd,
           ld_valid, ld_rd, ld_data, ld_funct3, ld_offset, chk_a1, chk_a2,
    input  ld_ready, we3, a3, wd3, busy1, busy2
  );

  modport slave (
    input  alu_valid, alu_rd, alu_result, ld_issue, ld_issue_rd,
           ld_valid, ld_rd, ld_data, ld_funct3, ld_offset, chk_a1, chk_a2,
    output ld_ready, we3, a3, wd3, busy1, busy2
  );
endinterface

// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - merges ALU results and extended load returns onto the register-file write port
// Also keeps the per-register pending-load scoreboard that decode checks for stalls.
module writeback_unit #(
  parameter int REG_BITS  = 32,
  parameter int ADDR_BITS = 5,
  parameter int LQ_DEPTH  = 2
) (
  input logic             clk,
  input logic             rst,
  writeback_unit_if.slave wb
);
  localparam int PW   = $clog2(LQ_DEPTH);
  localparam int CW   = PW + 1;
  localparam int NREG = 1 << ADDR_BITS;

  logic [REG_BITS-1:0]  lq_data_q [LQ_DEPTH];
  logic [ADDR_BITS-1:0] lq_rd_q   [LQ_DEPTH];
  logic [PW-1:0]        rptr_q;
  logic [PW-1:0]        wptr_q;
  logic [CW-1:0]        cnt_q;

  logic                 we3_q, we3_d;
  logic                 from_ld_q, from_ld_d;
  logic [ADDR_BITS-1:0] a3_q, a3_d;
  logic [REG_BITS-1:0]  wd3_q, wd3_d;
  logic [NREG-1:0]      sb_q, sb_d;

  logic full, empty, push, pop;

  function automatic logic [REG_BITS-1:0] extend(input logic [REG_BITS-1:0] data,
                                                 input logic [2:0] funct3,
                                                 input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    b = data[{off, 3'b000} +: 8];
    h = data[{off[1], 4'b0000} +: 16];
    case (funct3)
      3'b000:  extend = {{(REG_BITS-8){b[7]}}, b};
      3'b001:  extend = {{(REG_BITS-16){h[15]}}, h};
      3'b100:  extend = {{(REG_BITS-8){1'b0}}, b};
      3'b101:  extend = {{(REG_BITS-16){1'b0}}, h};
      default: extend = data;
    endcase
  endfunction

  // ready depends on registered occupancy only: a full queue never accepts, even while popping
  assign full        = (cnt_q == CW'(LQ_DEPTH));
  assign empty       = (cnt_q == '0);
  assign push        = wb.ld_valid && !full;
  assign pop         = !wb.alu_valid && !empty;
  assign wb.ld_ready = !full;

  always_ff @(posedge clk) begin
    if (push) begin
      lq_data_q[wptr_q] <= extend(wb.ld_data, wb.ld_funct3, wb.ld_offset);
      lq_rd_q[wptr_q]   <= wb.ld_rd;
    end
  end

  always_comb begin
    we3_d     = 1'b0;
    from_ld_d = 1'b0;
    a3_d      = a3_q;
    wd3_d     = wd3_q;
    if (wb.alu_valid) begin
      we3_d = (wb.alu_rd != '0);
      a3_d  = wb.alu_rd;
      wd3_d = wb.alu_result;
    end else if (pop) begin
      we3_d     = (lq_rd_q[rptr_q] != '0);
      from_ld_d = 1'b1;
      a3_d      = lq_rd_q[rptr_q];
      wd3_d     = lq_data_q[rptr_q];
    end
  end

  // a load write visible on we3 clears its bit one edge later; a same-edge reissue wins
  always_comb begin
    sb_d = sb_q;
    if (we3_q && from_ld_q) begin
      sb_d[a3_q] = 1'b0;
    end
    if (wb.ld_issue && (wb.ld_issue_rd != '0)) begin
      sb_d[wb.ld_issue_rd] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr_q    <= '0;
      wptr_q    <= '0;
      cnt_q     <= '0;
      we3_q     <= 1'b0;
      from_ld_q <= 1'b0;
      a3_q      <= '0;
      wd3_q     <= '0;
      sb_q      <= '0;
    end else begin
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
      we3_q     <= we3_d;
      from_ld_q <= from_ld_d;
      a3_q      <= a3_d;
      wd3_q     <= wd3_d;
      sb_q      <= sb_d;
    end
  end

  assign wb.we3   = we3_q;
  assign wb.a3    = a3_q;
  assign wb.wd3   = wd3_q;
  assign wb.busy1 = sb_q[wb.chk_a1];
  assign wb.busy2 = sb_q[wb.chk_a2];
endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - randomized self-checking bench for writeback_unit against a queue-based model
module tb_writeback_unit;
  localparam int LQ = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  writeback_unit_if #(.REG_BITS(32), .ADDR_BITS(5)) bus ();
  writeback_unit #(.REG_BITS(32), .ADDR_BITS(5), .LQ_DEPTH(LQ)) dut (
    .clk(clk),
    .rst(rst),
    .wb (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [4:0]  q_rd[$];
  logic [31:0] q_data[$];
  logic [31:0] m_sb;
  logic        m_we, m_fl, m_push;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  logic [40:0] exp_v, got_v;

  function automatic logic [31:0] ref_ext(input logic [31:0] d, input logic [2:0] f3, input int off);
    logic [31:0] b, h;
    b = (d >> (8 * off)) & 32'hFF;
    h = (d >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return b[7] ? (b | 32'hFFFF_FF00) : b;
      3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return d;
    endcase
  endfunction

  task automatic model_reset();
    q_rd.delete();
    q_data.delete();
    m_sb = '0;
    m_we = 1'b0;
    m_fl = 1'b0;
    m_a3 = '0;
    m_wd = '0;
    m_push = 1'b0;
  endtask

  task automatic model_edge();
    logic [4:0] rd;
    logic       rdy;
    rdy    = (q_rd.size() < LQ);
    m_push = bus.ld_valid && rdy;
    if (m_we && m_fl) m_sb[m_a3] = 1'b0;
    if (bus.ld_issue && bus.ld_issue_rd != 0) m_sb[bus.ld_issue_rd] = 1'b1;
    if (bus.alu_valid) begin
      m_we = (bus.alu_rd != 0);
      m_a3 = bus.alu_rd;
      m_wd = bus.alu_result;
      m_fl = 1'b0;
    end else if (q_rd.size() > 0) begin
      rd   = q_rd.pop_front();
      m_wd = q_data.pop_front();
      m_we = (rd != 0);
      m_a3 = rd;
      m_fl = 1'b1;
    end else begin
      m_we = 1'b0;
      m_fl = 1'b0;
    end
    if (m_push) begin
      q_rd.push_back(bus.ld_rd);
      q_data.push_back(ref_ext(bus.ld_data, bus.ld_funct3, int'(bus.ld_offset)));
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    exp_v = {m_we, m_a3, m_wd, (q_rd.size() < LQ), m_sb[bus.chk_a1], m_sb[bus.chk_a2]};
    got_v = {bus.we3, bus.a3, bus.wd3, bus.ld_ready, bus.busy1, bus.busy2};
  endtask

  task automatic idle();
    bus.alu_valid = 0; bus.alu_rd = 0; bus.alu_result = 0;
    bus.ld_issue = 0; bus.ld_issue_rd = 0;
    bus.ld_valid = 0; bus.ld_rd = 0; bus.ld_data = 0; bus.ld_funct3 = 0; bus.ld_offset = 0;
  endtask

  task automatic test_reset();
    idle();
    bus.chk_a1 = 5; bus.chk_a2 = 7;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    n_cmp++;
    if ({bus.we3, bus.a3, bus.wd3, bus.ld_ready, bus.busy1, bus.busy2} !== {1'b1 == 1'b0, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0}) begin
      n_bad++; $display("FAIL reset_state: got we3=%b a3=%0d wd3=%h rdy=%b busy=%b%b", bus.we3, bus.a3, bus.wd3, bus.ld_ready, bus.busy1, bus.busy2);
    end
    bus.ld_issue = 1; bus.ld_issue_rd = 5;
    tick();
    idle();
    bus.alu_valid = 1; bus.alu_rd = 1; bus.alu_result = $urandom;
    bus.ld_valid = 1; bus.ld_rd = 4; bus.ld_funct3 = 3'd2;
    for (int i = 0; i < 2; i++) begin
      bus.ld_data = $urandom;
      tick();
      n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL reset_fill: got %h exp %h", got_v, exp_v); end
    end
    n_cmp++;
    if ({bus.ld_ready, bus.busy1} !== 2'b01) begin
      n_bad++; $display("FAIL reset_prefill: got rdy=%b busy1=%b exp rdy=0 busy1=1", bus.ld_ready, bus.busy1);
    end
    #2 rst = 1;
    #1;
    n_cmp++;
    if ({bus.we3, bus.ld_ready, bus.busy1} !== 3'b010) begin
      n_bad++; $display("FAIL reset_mid: got we3=%b rdy=%b busy1=%b exp 0 1 0", bus.we3, bus.ld_ready, bus.busy1);
    end
    idle();
    @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++;
      if (bus.we3 !== 1'b0 || got_v !== exp_v) begin n_bad++; $display("FAIL reset_nowrite: got we3=%b vec %h exp %h", bus.we3, got_v, exp_v); end
    end
  endtask

  task automatic test_alu();
    idle();
    bus.alu_valid = 1; bus.alu_rd = 3; bus.alu_result = 32'hDEAD_BEEF;
    tick();
    n_cmp++;
    if ({bus.we3, bus.a3, bus.wd3} !== {1'b1, 5'd3, 32'hDEAD_BEEF}) begin
      n_bad++; $display("FAIL alu_write: got we3=%b a3=%0d wd3=%h exp 1 3 deadbeef", bus.we3, bus.a3, bus.wd3);
    end
    bus.alu_rd = 0; bus.alu_result = 32'h0000_1234;
    tick();
    n_cmp++;
    if (bus.we3 !== 1'b0 || got_v !== exp_v) begin n_bad++; $display("FAIL alu_x0: got we3=%b vec %h exp %h", bus.we3, got_v, exp_v); end
    idle();
    tick();
    n_cmp++;
    if (got_v !== exp_v) begin n_bad++; $display("FAIL alu_idle: got %h exp %h", got_v, exp_v); end
  endtask

  task automatic test_extension();
    logic [2:0]  f3  [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b011};
    logic [1:0]  off [5] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd0};
    logic [31:0] res [5] = '{32'hFFFF_FF80, 32'h0000_007F, 32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    for (int i = 0; i < 5; i++) begin
      idle();
      bus.ld_valid = 1; bus.ld_rd = 9; bus.ld_data = 32'h80FF_7F01;
      bus.ld_funct3 = f3[i]; bus.ld_offset = off[i];
      tick();
      idle();
      tick();
      n_cmp++;
      if ({bus.we3, bus.a3, bus.wd3} !== {1'b1, 5'd9, res[i]} || got_v !== exp_v) begin
        n_bad++; $display("FAIL ext_%0d: got we3=%b a3=%0d wd3=%h exp 1 9 %h", i, bus.we3, bus.a3, bus.wd3, res[i]);
      end
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] sent[3];
    int li = 0;
    int nw = 0;
    for (int k = 0; k < 3; k++) sent[k] = $urandom;
    idle();
    for (int c = 0; c < 11; c++) begin
      bus.alu_valid = (c < 5); bus.alu_rd = 5'($urandom_range(1, 31)); bus.alu_result = $urandom;
      bus.ld_valid = (li < 3); bus.ld_rd = 5'(10 + li); bus.ld_data = sent[li % 3]; bus.ld_funct3 = 3'd2;
      tick();
      if (m_push) li++;
      if (c >= 5 && bus.we3) begin
        n_cmp++;
        if (nw > 2 || {bus.a3, bus.wd3} !== {5'(10 + nw), sent[nw % 3]}) begin
          n_bad++; $display("FAIL bp_order_%0d: got a3=%0d wd3=%h", nw, bus.a3, bus.wd3);
        end
        nw++;
      end
      n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL bp_cycle_%0d: got %h exp %h", c, got_v, exp_v); end
      if (c == 4) begin
        n_cmp++;
        if (li !== 2 || bus.ld_ready !== 1'b0) begin n_bad++; $display("FAIL bp_stall: got accepts=%0d rdy=%b exp 2 0", li, bus.ld_ready); end
      end
    end
    n_cmp++;
    if (nw !== 3 || bus.ld_ready !== 1'b1) begin n_bad++; $display("FAIL bp_drain: got writes=%0d rdy=%b exp 3 1", nw, bus.ld_ready); end
  endtask

  task automatic test_scoreboard();
    logic [4:0] exp_busy [8];
    idle();
    bus.chk_a1 = 7; bus.chk_a2 = 0;
    bus.ld_issue = 1; bus.ld_issue_rd = 0;
    tick();
    n_cmp++;
    if (bus.busy2 !== 1'b0) begin n_bad++; $display("FAIL sb_x0: got busy2=%b exp 0", bus.busy2); end
    for (int pass = 0; pass < 2; pass++) begin
      idle();
      bus.ld_issue = (pass == 0); bus.ld_issue_rd = 7;
      tick();
      idle();
      bus.ld_valid = 1; bus.ld_rd = 7; bus.ld_data = $urandom; bus.ld_funct3 = 3'd2;
      tick();
      idle();
      tick();
      n_cmp++;
      if ({bus.we3, bus.a3, bus.busy1} !== {1'b1, 5'd7, 1'b1}) begin
        n_bad++; $display("FAIL sb_commit_%0d: got we3=%b a3=%0d busy1=%b exp 1 7 1", pass, bus.we3, bus.a3, bus.busy1);
      end
      bus.ld_issue = (pass == 0); bus.ld_issue_rd = 7;
      tick();
      idle();
      n_cmp++;
      if (bus.busy1 !== (pass == 0) || got_v !== exp_v) begin
        n_bad++; $display("FAIL sb_clear_%0d: got busy1=%b exp %b", pass, bus.busy1, pass == 0);
      end
    end
  endtask

  task automatic test_wraparound();
    logic [4:0]  s_rd[10];
    logic [31:0] s_dat[10], s_exp[10];
    logic [2:0]  s_f3[10];
    logic [1:0]  s_off[10];
    int li = 0;
    int nw = 0;
    for (int k = 0; k < 10; k++) begin
      s_rd[k] = 5'($urandom_range(1, 31)); s_dat[k] = $urandom;
      s_f3[k] = 3'($urandom); s_off[k] = 2'($urandom);
      s_exp[k] = ref_ext(s_dat[k], s_f3[k], int'(s_off[k]));
    end
    idle();
    for (int c = 0; c < 40 && nw < 10; c++) begin
      bus.ld_valid = (li < 10);
      bus.ld_rd = s_rd[li % 10]; bus.ld_data = s_dat[li % 10];
      bus.ld_funct3 = s_f3[li % 10]; bus.ld_offset = s_off[li % 10];
      tick();
      if (m_push) li++;
      if (bus.we3) begin
        n_cmp++;
        if ({bus.a3, bus.wd3} !== {s_rd[nw], s_exp[nw]}) begin
          n_bad++; $display("FAIL wrap_%0d: got a3=%0d wd3=%h exp %0d %h", nw, bus.a3, bus.wd3, s_rd[nw], s_exp[nw]);
        end
        nw++;
      end
      n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL wrap_cycle_%0d: got %h exp %h", c, got_v, exp_v); end
    end
    n_cmp++;
    if (nw !== 10) begin n_bad++; $display("FAIL wrap_count: got %0d exp 10", nw); end
    idle();
    repeat (2) tick();
  endtask

  task automatic test_random();
    idle();
    for (int c = 0; c < 400; c++) begin
      bus.alu_valid = ($urandom_range(0, 9) < 4);
      bus.alu_rd = 5'($urandom); bus.alu_result = $urandom;
      bus.ld_issue = $urandom_range(0, 1); bus.ld_issue_rd = 5'($urandom);
      if (!bus.ld_valid || m_push) begin
        bus.ld_valid = $urandom_range(0, 1);
        bus.ld_rd = 5'($urandom); bus.ld_data = $urandom;
        bus.ld_funct3 = 3'($urandom); bus.ld_offset = 2'($urandom);
      end
      bus.chk_a1 = 5'($urandom); bus.chk_a2 = 5'($urandom);
      #1;
      n_cmp++;
      if ({bus.ld_ready, bus.busy1, bus.busy2} !== {(q_rd.size() < LQ), m_sb[bus.chk_a1], m_sb[bus.chk_a2]}) begin
        n_bad++; $display("FAIL rand_comb_%0d: got rdy=%b busy=%b%b", c, bus.ld_ready, bus.busy1, bus.busy2);
      end
      tick();
      n_cmp++;
      if (got_v !== exp_v) begin n_bad++; $display("FAIL rand_cycle_%0d: got %h exp %h", c, got_v, exp_v); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_alu();
    test_extension();
    test_back_to_back();
    test_scoreboard();
    test_wraparound();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Drives the register-file write port (we3/a3/wd3) for the core.
- Merges two producers: single-cycle ALU results and load returns from the LSU. Load returns are held in a small load-return queue.
- Applies RV32I load byte/halfword extension before the write.
- Keeps a per-register pending-load scoreboard. Decode queries it through two check ports to decide whether to stall.

Parameters:
- REG_BITS, 32, data width of register and write data
- ADDR_BITS, 5, register address width (2**ADDR_BITS registers)
- LQ_DEPTH, 2, load-return queue entries (power of two, >=2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle; must always be accepted
- alu_rd  in  ADDR_BITS  ALU destination register
- alu_result  in  REG_BITS  ALU result
- ld_issue  in  1  load issued this cycle; marks ld_issue_rd pending
- ld_issue_rd  in  ADDR_BITS  destination of issued load
- ld_valid  in  1  load return valid
- ld_ready  out  1  queue can accept a load return
- ld_rd  in  ADDR_BITS  load return destination
- ld_data  in  REG_BITS  raw aligned memory word
- ld_funct3  in  3  load type (RV32I funct3)
- ld_offset  in  2  byte offset, address[1:0]
- we3  out  1  register-file write enable
- a3  out  ADDR_BITS  write address
- wd3  out  REG_BITS  write data
- chk_a1, chk_a2  in  ADDR_BITS  decode source registers
- busy1, busy2  out  1  pending-load flag for chk_a1/chk_a2, combinational

Behaviour:
- Reset (async, rst=1):
  - we3=0, a3=0, wd3=0.
  - Queue emptied; ld_ready=1 once reset releases.
  - All scoreboard bits cleared; busy1=busy2=0.
  - Reset mid-operation discards queued loads and pending bits. No write is issued for them.
- we3, a3 and wd3 are registered.
- Load-return handshake:
  - A transfer occurs on a clock edge with ld_valid && ld_ready.
  - ld_ready = !full, registered-state based. There is no pass-through when full, even if a pop happens the same cycle.
  - ld_valid may be held while ld_ready=0. Data must stay stable until the transfer.
- Extension at enqueue. Select byte = ld_data[8*off+:8], half = ld_data[16*off[1]+:16]:
  - 000 LB: sign-extend byte
  - 001 LH: sign-extend half
  - 100 LBU: zero-extend byte
  - 101 LHU: zero-extend half
  - 010 LW and all undefined codes: raw word
  - off[0] is ignored for halfword loads.
- Write selection each cycle, fixed priority:
  1. alu_valid: on the next edge, we3 <= (alu_rd!=0), a3 <= alu_rd, wd3 <= alu_result.
  2. Otherwise, queue non-empty: pop the head; we3 <= (rd!=0), a3/wd3 from the head.
  3. Otherwise: we3 <= 0; a3/wd3 hold their previous values.
- Latency:
  - ALU: valid in cycle t gives we3 high in cycle t+1.
  - Load: handshake in cycle t gives we3 high in cycle t+2 at earliest.
  - A continuous ALU stream starves the queue. Loads then back-pressure through ld_ready; this is intended, and the pipeline inserts bubbles.
- x0 handling: writes to register 0 are suppressed (we3=0). A rd=0 load still occupies and pops a queue slot.
- Queue ordering: FIFO in arrival order. Wrap-around uses pointers modulo LQ_DEPTH plus a count (or an extra pointer bit).
- Simultaneous push and pop when non-full: both happen; count is unchanged.
- Scoreboard (2**ADDR_BITS bits):
  - Set: ld_issue && ld_issue_rd!=0 sets the bit on the edge.
  - Clear: a load write commits on the edge where we3=1 from a load entry. The bit is cleared on the following edge, so busy drops the cycle after we3 was high.
  - If set and clear hit the same register on the same edge, set wins.
  - Bit 0 is never set.
  - busy1 = sb[chk_a1], busy2 = sb[chk_a2], with no bypass.
- ALU writes never touch the scoreboard.

Test Plan:
- Reset: assert rst mid-stream with 2 loads queued and sb[5]=1 -> we3=0, ld_ready=1, busy for reg 5 =0; no write of queued data after release.
- ALU path: alu_valid, rd=3, result=0xDEADBEEF in cycle t -> we3=1, a3=3, wd3=0xDEADBEEF in t+1; rd=0 -> we3=0.
- Extension:
  - ld_data=0x80FF7F01, LB off=3 -> 0xFFFFFF80
  - LBU off=1 -> 0x0000007F
  - LH off=2 -> 0xFFFF80FF
  - LHU off=0 -> 0x00007F01
  - funct3=011 -> 0x80FF7F01
- Priority and backpressure: alu_valid held 5 cycles while 3 loads are offered (LQ_DEPTH=2) -> ld_ready drops after 2 accepts; after ALU stops, loads write in order on consecutive cycles, then ld_ready=1.
- Scoreboard: ld_issue rd=7 -> busy1=1 with chk_a1=7 until the cycle after the load's we3; same-edge reissue to 7 during clear -> busy stays 1.
- Wrap-around: 10 back-to-back loads, no ALU traffic, ld_valid held -> all 10 written in order with correct data; no drop or duplicate.
